// File: rtl/mprj_io_stim.sv
// Per-pad stimulus and edge-count monitor for the user-project I/O bus.
// Each channel floats, drives a level, or plays a serial pattern on a shared tick.
module mprj_io_stim #(
  parameter int NUM_IO    = 38,
  parameter int PAT_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic                      clock,
  input  logic                      resetb,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_IO)-1:0] cfg_ch,
  input  logic [1:0]                cfg_mode,
  input  logic                      cfg_val,
  input  logic [PAT_DEPTH-1:0]      cfg_pattern,
  input  logic [7:0]                tick_div,
  input  logic                      cnt_clr,
  input  logic [NUM_IO-1:0]         io_in,
  output logic [NUM_IO-1:0]         io_out,
  output logic [NUM_IO-1:0]         io_oe,
  output logic [NUM_IO-1:0]         done,
  input  logic [$clog2(NUM_IO)-1:0] rd_ch,
  output logic [CNT_W-1:0]          rd_count
);
  localparam int CH_W  = $clog2(NUM_IO);
  localparam int IDX_W = $clog2(PAT_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_DEPTH - 1);

  typedef enum logic [1:0] {
    MODE_HIZ     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_REPEAT  = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  mode_e              mode_q [NUM_IO];
  mode_e              mode_d [NUM_IO];
  logic [PAT_DEPTH-1:0] pat_q [NUM_IO];
  logic [PAT_DEPTH-1:0] pat_d [NUM_IO];
  logic [IDX_W-1:0]   idx_q  [NUM_IO];
  logic [IDX_W-1:0]   idx_d  [NUM_IO];
  logic [CNT_W-1:0]   cnt_q  [NUM_IO];
  logic [CNT_W-1:0]   cnt_d  [NUM_IO];
  logic [NUM_IO-1:0]  val_q, val_d;
  logic [NUM_IO-1:0]  done_q, done_d;
  logic [NUM_IO-1:0]  oe_q, oe_d;
  logic [NUM_IO-1:0]  out_q, out_d;
  logic [NUM_IO-1:0]  sync1_q, sync2_q, prev_q;
  logic [NUM_IO-1:0]  edge_det;
  logic [7:0]         tick_cnt_q, tick_cnt_d;
  logic               tick;

  // One shared down-counter; tick_div is only sampled on reload so a change
  // lands at the end of the running period.
  assign tick     = (tick_cnt_q == 8'd0);
  assign edge_det = sync2_q ^ prev_q;

  always_comb begin
    tick_cnt_d = tick ? tick_div : tick_cnt_q - 8'd1;
    val_d      = val_q;
    done_d     = done_q;
    oe_d       = '0;
    out_d      = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      mode_d[i] = mode_q[i];
      pat_d[i]  = pat_q[i];
      idx_d[i]  = idx_q[i];
      cnt_d[i]  = cnt_q[i];
      if (cfg_we && cfg_ch == CH_W'(i)) begin
        mode_d[i] = mode_e'(cfg_mode);
        val_d[i]  = cfg_val;
        pat_d[i]  = cfg_pattern;
        idx_d[i]  = '0;
        done_d[i] = 1'b0;
      end else if (tick && (mode_q[i] == MODE_REPEAT || mode_q[i] == MODE_ONESHOT)) begin
        if (idx_q[i] != IDX_LAST)
          idx_d[i] = idx_q[i] + 1'b1;
        else if (mode_q[i] == MODE_ONESHOT)
          done_d[i] = 1'b1;
        else
          idx_d[i] = '0;
      end
      if (cnt_clr) begin
        done_d[i] = 1'b0;
        cnt_d[i]  = '0;
      end else if (edge_det[i] && cnt_q[i] != {CNT_W{1'b1}}) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
      // Pad drive is computed from next state so outputs stay registered.
      oe_d[i] = (mode_d[i] != MODE_HIZ);
      case (mode_d[i])
        MODE_HIZ:    out_d[i] = 1'b0;
        MODE_STATIC: out_d[i] = val_d[i];
        default:     out_d[i] = pat_d[i][idx_d[i]];
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tick_cnt_q <= '0;
      val_q      <= '0;
      done_q     <= '0;
      oe_q       <= '0;
      out_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      for (int i = 0; i < NUM_IO; i++) begin
        mode_q[i] <= MODE_HIZ;
        pat_q[i]  <= '0;
        idx_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      val_q      <= val_d;
      done_q     <= done_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      sync1_q    <= io_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      for (int i = 0; i < NUM_IO; i++) begin
        mode_q[i] <= mode_d[i];
        pat_q[i]  <= pat_d[i];
        idx_q[i]  <= idx_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rd_count = '0;
    for (int i = 0; i < NUM_IO; i++)
      if (rd_ch == CH_W'(i)) rd_count = cnt_q[i];
  end

  assign io_oe  = oe_q;
  assign io_out = out_q;
  assign done   = done_q;

endmodule
